dual_port_ram: RTL and testbench



---
 rtl/dual_port_ram_pkg.sv | 20 ++
 rtl/dual_port_ram_port.sv | 61 ++++++
 rtl/dual_port_ram.sv | 69 ++++++
 tb/tb_dual_port_ram.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/dual_port_ram_pkg.sv
// dual_port_ram_pkg
// Shared definitions for the dual-port RAM: default geometry and the
// per-port write-mode selector.
package dual_port_ram_pkg;

  localparam int DPR_ADDR_WIDTH = 10;
  localparam int DPR_DATA_WIDTH = 16;
  localparam int DPR_DEPTH      = 1 << DPR_ADDR_WIDTH;

  // Behaviour of rd_data during a write on that port:
  //   NORMAL_WRITE      - rd_data holds its previous value
  //   TRANSPARENT_WRITE - rd_data shows the data being written
  //   READ_BEFORE_WRITE - rd_data shows the cell contents before the write
  typedef enum logic [1:0] {
    NORMAL_WRITE,
    TRANSPARENT_WRITE,
    READ_BEFORE_WRITE
  } wr_mode_e;

endpackage

// File: rtl/dual_port_ram_port.sv
// dual_port_ram_port
// Per-port read path: the array read register with write-mode mux, plus an
// optional output pipeline register (macro DUAL_PORT_RAM_OUTREG_EN).
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   wr_en         - this port writes this cycle
//   wr_data       - this port's write data
//   mem_rd_data   - current array contents at this port's address (old data)
//   rd_data       - registered read data (1 or 2 cycles latency)
module dual_port_ram_port
  import dual_port_ram_pkg::*;
#(
  parameter wr_mode_e WR_MODE    = NORMAL_WRITE,
  parameter int       DATA_WIDTH = DPR_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] rd_d;
  logic [DATA_WIDTH-1:0] rd_q;

  always_comb begin
    rd_d = mem_rd_data;
    if (wr_en) begin
      case (WR_MODE)
        TRANSPARENT_WRITE: rd_d = wr_data;
        NORMAL_WRITE:      rd_d = rd_q;
        default:           rd_d = mem_rd_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_d;
  end

`ifdef DUAL_PORT_RAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] out_d;
  logic [DATA_WIDTH-1:0] out_q;

  always_comb begin
    out_d = rd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign rd_data = out_q;
`else
  assign rd_data = rd_q;
`endif

endmodule

// File: rtl/dual_port_ram.sv
// dual_port_ram
// Synchronous true dual-port RAM sharing one clock. Port A is write-first
// (transparent), port B is no-change. Cross-port reads of a cell being
// written return the old contents. On a same-address double write port A
// wins. Optional output register via macro DUAL_PORT_RAM_OUTREG_EN.
// Ports:
//   clk, rst                              - clock, synchronous active-high reset
//   a_addr, a_wr_data, a_wr_en, a_rd_data - port A
//   b_addr, b_wr_data, b_wr_en, b_rd_data - port B
module dual_port_ram
  import dual_port_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DPR_ADDR_WIDTH,
  parameter int DATA_WIDTH = DPR_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wr_data,
  input  logic                  a_wr_en,
  output logic [DATA_WIDTH-1:0] a_rd_data,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wr_data,
  input  logic                  b_wr_en,
  output logic [DATA_WIDTH-1:0] b_rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  a_we_d;
  logic                  b_we_d;

  // Writes are dropped during reset; B loses a same-address collision.
  always_comb begin
    a_we_d = a_wr_en & ~rst;
    b_we_d = b_wr_en & ~rst & ~(a_wr_en & (a_addr == b_addr));
  end

  always_ff @(posedge clk) begin
    if (a_we_d) mem_q[a_addr] <= a_wr_data;
    if (b_we_d) mem_q[b_addr] <= b_wr_data;
  end

  dual_port_ram_port #(
    .WR_MODE    (TRANSPARENT_WRITE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_port_a (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (a_wr_en),
    .wr_data     (a_wr_data),
    .mem_rd_data (mem_q[a_addr]),
    .rd_data     (a_rd_data)
  );

  dual_port_ram_port #(
    .WR_MODE    (NORMAL_WRITE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_port_b (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (b_wr_en),
    .wr_data     (b_wr_data),
    .mem_rd_data (mem_q[b_addr]),
    .rd_data     (b_rd_data)
  );

endmodule

// File: tb/tb_dual_port_ram.sv
module tb_dual_port_ram;

`ifdef DUAL_PORT_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  a_addr;
  logic [15:0] a_wr_data;
  logic        a_wr_en;
  logic [15:0] a_rd_data;
  logic [9:0]  b_addr;
  logic [15:0] b_wr_data;
  logic        b_wr_en;
  logic [15:0] b_rd_data;

  int vec_cnt = 0;
  int err_cnt = 0;

  dual_port_ram dut (
    .clk       (clk),
    .rst       (rst),
    .a_addr    (a_addr),
    .a_wr_data (a_wr_data),
    .a_wr_en   (a_wr_en),
    .a_rd_data (a_rd_data),
    .b_addr    (b_addr),
    .b_wr_data (b_wr_data),
    .b_wr_en   (b_wr_en),
    .b_rd_data (b_rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] pat(input int a);
    return 16'(32'hFFFF - a);
  endfunction

  initial begin
    rst = 1'b1;
    a_addr = '0; a_wr_data = '0; a_wr_en = 1'b0;
    b_addr = '0; b_wr_data = '0; b_wr_en = 1'b0;
    tick(); tick();
    check_vec("reset_a", a_rd_data, 16'h0000);
    check_vec("reset_b", b_rd_data, 16'h0000);
    rst = 1'b0;

    // Fill from A; transparent port A echoes each written word.
    for (int i = 0; i < DEPTH + LAT - 1; i++) begin
      if (i < DEPTH) begin
        a_addr = 10'(i); a_wr_data = pat(i); a_wr_en = 1'b1;
      end else begin
        a_wr_en = 1'b0; a_addr = '0;
      end
      tick();
      if (i - (LAT - 1) >= 0) check_vec("a_wr_echo", a_rd_data, pat(i - (LAT - 1)));
    end
    a_wr_en = 1'b0;

    // Stream reads: A ascending, B descending.
    for (int i = 0; i < DEPTH + LAT - 1; i++) begin
      if (i < DEPTH) begin
        a_addr = 10'(i);
        b_addr = 10'(DEPTH - 1 - i);
      end
      tick();
      if (i - (LAT - 1) >= 0) begin
        check_vec("a_read", a_rd_data, pat(i - (LAT - 1)));
        check_vec("b_read", b_rd_data, pat(DEPTH - 1 - (i - (LAT - 1))));
      end
    end

    // Port B no-change write.
    a_addr = 10'd0; b_addr = 10'd10;
    for (int k = 0; k < LAT; k++) tick();
    check_vec("b_pre", b_rd_data, 16'hFFF5);
    b_addr = 10'd5; b_wr_data = 16'h1234; b_wr_en = 1'b1;
    for (int k = 0; k <= LAT; k++) begin
      tick();
      check_vec("b_wr_hold", b_rd_data, 16'hFFF5);
    end
    b_wr_en = 1'b0; b_addr = 10'd11; a_addr = 10'd5;
    for (int k = 0; k < LAT; k++) tick();
    check_vec("a_rd_bwr", a_rd_data, 16'h1234);
    check_vec("b_rd_11", b_rd_data, 16'hFFF4);

    // Port A transparency, B reads the same cell (old data).
    a_addr = 10'd7; a_wr_data = 16'hABCD; a_wr_en = 1'b1; b_addr = 10'd7;
    tick();
    a_wr_en = 1'b0;
    for (int k = 1; k < LAT; k++) tick();
    check_vec("a_transp", a_rd_data, 16'hABCD);
    check_vec("b_old", b_rd_data, 16'hFFF8);
    tick();
    check_vec("a_rd7", a_rd_data, 16'hABCD);
    check_vec("b_rd7_new", b_rd_data, 16'hABCD);

    // Same-address collision: A wins, B output holds.
    a_addr = 10'd3; a_wr_data = 16'h1111; a_wr_en = 1'b1;
    b_addr = 10'd3; b_wr_data = 16'h2222; b_wr_en = 1'b1;
    tick();
    a_wr_en = 1'b0; b_wr_en = 1'b0;
    for (int k = 1; k < LAT; k++) tick();
    check_vec("coll_a", a_rd_data, 16'h1111);
    check_vec("coll_b_hold", b_rd_data, 16'hABCD);
    tick();
    check_vec("coll_a_rd", a_rd_data, 16'h1111);
    check_vec("coll_b_rd", b_rd_data, 16'h1111);

    // Reset mid-operation: writes during reset are dropped.
    a_addr = 10'd9; a_wr_data = 16'h5555; a_wr_en = 1'b1;
    tick();
    a_wr_en = 1'b0; b_addr = 10'd9;
    for (int k = 0; k < LAT; k++) tick();
    check_vec("pre_rst_b9", b_rd_data, 16'h5555);
    rst = 1'b1;
    a_addr = 10'd9; a_wr_data = 16'h0F0F; a_wr_en = 1'b1;
    b_addr = 10'd20; b_wr_data = 16'h7777; b_wr_en = 1'b1;
    tick();
    check_vec("rst_a", a_rd_data, 16'h0000);
    check_vec("rst_b", b_rd_data, 16'h0000);
    rst = 1'b0; a_wr_en = 1'b0; b_wr_en = 1'b0;
    a_addr = 10'd9; b_addr = 10'd20;
    tick();
    if (LAT == 2) begin
      check_vec("post_rst_a_lat", a_rd_data, 16'h0000);
      check_vec("post_rst_b_lat", b_rd_data, 16'h0000);
      tick();
    end
    check_vec("post_rst_a9", a_rd_data, 16'h5555);
    check_vec("post_rst_b20", b_rd_data, 16'hFFEB);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
